// File: rtl/ans_table_loader_pkg.sv
// Shared defaults, FSM state encoding and width helper for the rANS table loader.
package ans_table_loader_pkg;
    localparam int SYM_COUNT_DEF = 16;
    localparam int CNT_WIDTH_DEF = 8;
    localparam int PREC_BITS_DEF = 8;

    typedef enum logic [1:0] {ST_LOAD, ST_CHECK, ST_DONE} state_e;

    // Running sum of SYM_COUNT counts can never exceed this width.
    function automatic int tot_width(input int sym_count, input int cnt_width);
        return cnt_width + $clog2(sym_count);
    endfunction

    localparam int TOT_WIDTH_DEF = tot_width(SYM_COUNT_DEF, CNT_WIDTH_DEF);
endpackage

// File: rtl/ans_table_loader_if.sv
// Producer-side load port and table outputs of the rANS table loader.
interface ans_table_loader_if
    import ans_table_loader_pkg::*;
#(
    parameter int SYM_COUNT = SYM_COUNT_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int TOT_WIDTH = TOT_WIDTH_DEF
);
    logic [CNT_WIDTH-1:0]                 data;
    logic                                 vld;
    logic                                 rdy;
    logic                                 clear;
    logic [SYM_COUNT-1:0][CNT_WIDTH-1:0]  counts;
    logic [SYM_COUNT-1:0][TOT_WIDTH-1:0]  cumul;
    logic [TOT_WIDTH-1:0]                 total;
    logic                                 table_vld;
    logic                                 table_err;

    modport master (output data, vld, clear,
                    input  rdy, counts, cumul, total, table_vld, table_err);
    modport slave  (input  data, vld, clear,
                    output rdy, counts, cumul, total, table_vld, table_err);
endinterface

// File: rtl/ans_table_loader_hs.sv
// Ready generation and accept pulse for the loader; HS_MODE 0 is four-phase, 1 is streaming.
module ans_hs_accept #(
    parameter int HS_MODE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vld_i,
    input  logic clear_i,
    input  logic load_i,
    input  logic next_load_i,
    output logic rdy_o,
    output logic acc_o
);
    logic rdy_q, rdy_d;

    assign acc_o = vld_i && rdy_q && load_i && !clear_i;
    assign rdy_o = rdy_q;

    generate
        if (HS_MODE == 0) begin : g_fourphase
            // Ready only returns once the producer has dropped valid, so a held word is taken once.
            always_comb begin
                rdy_d = rdy_q;
                if (!next_load_i)  rdy_d = 1'b0;
                else if (clear_i)  rdy_d = 1'b1;
                else if (acc_o)    rdy_d = 1'b0;
                else if (!vld_i)   rdy_d = 1'b1;
            end
        end else begin : g_stream
            always_comb rdy_d = next_load_i;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b1;
        else        rdy_q <= rdy_d;
    end
endmodule

// File: rtl/ans_table_loader.sv
// Serially loads SYM_COUNT symbol counts, builds count and cumulative tables, validates the total.
module ans_table_loader
    import ans_table_loader_pkg::*;
#(
    parameter int SYM_COUNT = SYM_COUNT_DEF,
    parameter int SYM_WIDTH = $clog2(SYM_COUNT),
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int PREC_BITS = PREC_BITS_DEF,
    parameter int TOT_WIDTH = CNT_WIDTH + SYM_WIDTH,
    parameter int HS_MODE   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    ans_table_loader_if.slave  bus
);
    localparam logic [SYM_WIDTH-1:0] LAST_IDX = SYM_WIDTH'(SYM_COUNT - 1);
    // Compare wide enough that a target outside TOT_WIDTH never aliases onto a real total.
    localparam int                   CMP_W    = ((TOT_WIDTH > PREC_BITS) ? TOT_WIDTH : PREC_BITS) + 1;
    localparam logic [CMP_W-1:0]     TARGET   = CMP_W'(1) << PREC_BITS;

    state_e                              state_q, state_d;
    logic [SYM_WIDTH-1:0]                idx_q, idx_d;
    logic [SYM_COUNT-1:0][CNT_WIDTH-1:0] counts_q, counts_d;
    logic [SYM_COUNT-1:0][TOT_WIDTH-1:0] cumul_q, cumul_d;
    logic [TOT_WIDTH-1:0]                total_q, total_d;
    logic                                tvld_q, tvld_d, terr_q, terr_d;
    logic                                acc, last_acc, total_ok;

    assign last_acc = acc && (idx_q == LAST_IDX);
    assign total_ok = (CMP_W'(total_q) == TARGET);

    ans_hs_accept #(.HS_MODE(HS_MODE)) u_hs (
        .clk         (clk),
        .rst_n       (rst_n),
        .vld_i       (bus.vld),
        .clear_i     (bus.clear),
        .load_i      (state_q == ST_LOAD),
        .next_load_i (state_d == ST_LOAD),
        .rdy_o       (bus.rdy),
        .acc_o       (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_LOAD;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) state_d = ST_LOAD;
        else begin
            unique case (state_q)
                ST_LOAD:  if (last_acc) state_d = ST_CHECK;
                ST_CHECK: state_d = ST_DONE;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_LOAD;
            endcase
        end
    end

    always_comb begin
        tvld_d = tvld_q;
        terr_d = terr_q;
        if (bus.clear) begin
            tvld_d = 1'b0;
            terr_d = 1'b0;
        end else if (state_q == ST_CHECK) begin
            tvld_d = total_ok;
            terr_d = !total_ok;
        end
    end

    always_comb begin
        idx_d    = idx_q;
        counts_d = counts_q;
        cumul_d  = cumul_q;
        total_d  = total_q;
        if (bus.clear) begin
            idx_d    = '0;
            counts_d = '0;
            cumul_d  = '0;
            total_d  = '0;
        end else if (acc) begin
            counts_d[idx_q] = bus.data;
            cumul_d[idx_q]  = total_q;
            total_d         = total_q + TOT_WIDTH'(bus.data);
            idx_d           = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            counts_q <= '0;
            cumul_q  <= '0;
            total_q  <= '0;
            tvld_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            counts_q <= counts_d;
            cumul_q  <= cumul_d;
            total_q  <= total_d;
            tvld_q   <= tvld_d;
            terr_q   <= terr_d;
        end
    end

    assign bus.counts    = counts_q;
    assign bus.cumul     = cumul_q;
    assign bus.total     = total_q;
    assign bus.table_vld = tvld_q;
    assign bus.table_err = terr_q;
endmodule
